// File: rtl/cpu_run_ctrl_pkg.sv
// ============================================================================
// Module : cpu_run_ctrl_pkg
// Brief  : Shared state encoding and helpers for the CPU run/step controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_run_ctrl_pkg;

  // Encoding is visible on the state port and read by the board debug mux.
  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_STEP  = 2'b01,
    ST_RUN   = 2'b10,
    ST_BREAK = 2'b11
  } run_state_e;

  function automatic logic state_is_halted(input run_state_e s);
    return (s == ST_HALT) || (s == ST_BREAK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_step_debouncer.sv
// ============================================================================
// Module : step_debouncer
// Brief  : Step-button synchroniser, debouncer and rising-edge pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic step_i,
  output logic step_evt_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= step_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign step_evt_o = stable_q & ~stable_dly_q;

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module : cpu_run_ctrl
// Brief  : Run/step/breakpoint sequencer issuing a one-clk cpu_tick enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DIV             = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        bp_enable,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic        clr_count,
  output logic        cpu_tick,
  output logic        halted,
  output logic        break_hit,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic             slot;
  logic             step_evt;
  run_state_e       state_q;
  run_state_e       state_d;
  logic             tick_q;
  logic             tick_d;
  logic [31:0]      cycle_count_q;
  logic [31:0]      cycle_count_d;

  step_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step),
    .step_evt_o (step_evt)
  );

  assign slot = (div_cnt_q == DIV_LAST);

  // Tick is decided in the slot cycle and presented, registered, one clk later.
  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (run)           state_d = ST_RUN;
        else if (step_evt) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (slot) begin
          tick_d  = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_HALT;
        end else if (slot) begin
          if (bp_enable && (pc == bp_addr)) state_d = ST_BREAK;
          else                              tick_d  = 1'b1;
        end
      end
      ST_BREAK: begin
        if (step_evt)  state_d = ST_STEP;
        else if (!run) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (clr_count)   cycle_count_d = '0;
    else if (tick_q) cycle_count_d = cycle_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      state_q       <= ST_HALT;
      tick_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      div_cnt_q     <= (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      state_q       <= state_d;
      tick_q        <= tick_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cpu_tick    = tick_q;
  assign halted      = state_is_halted(state_q);
  assign break_hit   = (state_q == ST_BREAK);
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// Module : tb_cpu_run_ctrl
// Brief  : Self-checking bench for cpu_run_ctrl (DIV=2, DEBOUNCE_CYCLES=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int DIV = 2;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        bp_enable = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc;
  logic        clr_count = 1'b0;
  logic        pc_clr = 1'b1;
  logic        cpu_tick;
  logic        halted;
  logic        break_hit;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned ecnt;
  int unsigned ticks = 0;
  logic [1:0]  last_state = 2'b00;
  logic [1:0]  seq_q[$];
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DIV             (DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .clr_count   (clr_count),
    .cpu_tick    (cpu_tick),
    .halted      (halted),
    .break_hit   (break_hit),
    .state       (state),
    .cycle_count (cycle_count)
  );

  // Edge count since reset release: the divider phase is ecnt mod DIV.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // Simple core stand-in: PC advances by one word per committed instruction.
  always @(posedge clk) begin
    if (pc_clr)        pc <= '0;
    else if (cpu_tick) pc <= pc + 32'd4;
  end

  always @(negedge clk) begin
    if (cpu_tick) ticks <= ticks + 1;
    if (state !== last_state) seq_q.push_back(state);
    last_state <= state;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slot cycles in the inclusive edge-count window [lo, hi].
  function automatic int slots_in(input int unsigned lo, input int unsigned hi);
    int s = 0;
    for (int unsigned n = lo; n <= hi; n++) if ((n % DIV) == DIV - 1) s++;
    return s;
  endfunction

  // Free-run from HALT for L clks with optional breakpoint at word b.
  task automatic burst(input string tag, input int L, input logic bpe, input int b,
                       input logic align, output int got);
    int unsigned k;
    int unsigned t0;
    int          s;
    int          exp_t;
    logic        broke;
    pc_clr = 1'b1;
    cyc(1);
    pc_clr = 1'b0;
    if (align && (ecnt % DIV) != 0) cyc(1);
    bp_enable = bpe;
    bp_addr   = 32'(b * 4);
    k  = ecnt;
    t0 = ticks;
    run = 1'b1;
    cyc(L);
    s     = slots_in(k + 1, k + L - 1);
    broke = bpe && (s > b);
    exp_t = (bpe && s > b) ? b : s;
    chk({tag, "_state_live"}, 32'(state), broke ? 32'd3 : 32'd2);
    chk({tag, "_break_hit"}, 32'(break_hit), 32'(broke));
    run = 1'b0;
    cyc(4);
    bp_enable = 1'b0;
    got = int'(ticks - t0);
    exp_cnt = exp_cnt + 32'(exp_t);
    chk({tag, "_ticks"}, 32'(got), 32'(exp_t));
    chk({tag, "_state_end"}, 32'(state), 32'd0);
    chk({tag, "_count"}, cycle_count, exp_cnt);
  endtask

  task automatic press(input string tag, input int len);
    int unsigned t0;
    int          exp_t;
    t0 = ticks;
    step = 1'b1;
    cyc(len);
    step = 1'b0;
    cyc(14);
    exp_t = (len >= DEB) ? 1 : 0;
    exp_cnt = exp_cnt + 32'(exp_t);
    chk({tag, "_ticks"}, ticks - t0, 32'(exp_t));
    chk({tag, "_count"}, cycle_count, exp_cnt);
    chk({tag, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    int          got;
    int unsigned t0;
    int unsigned t1;
    int          s0;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    pc_clr = 1'b0;
    #1;
    chk("t1_reset_state", 32'(state), 32'd0);
    chk("t1_reset_halted", 32'(halted), 32'd1);
    chk("t1_reset_tick", 32'(cpu_tick), 32'd0);
    cyc(50);
    chk("t1_idle_ticks", ticks, 32'd0);
    chk("t1_idle_halted", 32'(halted), 32'd1);
    chk("t1_idle_state", 32'(state), 32'd0);
    chk("t1_idle_count", cycle_count, 32'd0);

    // 2: 20 clk of run aligned to the divider phase
    burst("t2", 20, 1'b0, 0, 1'b1, got);
    chk("t2_ten_ticks", 32'(got), 32'd10);
    chk("t2_count_ten", cycle_count, 32'd10);

    // 3: glitch rejected, real press gives one step
    t0 = ticks;
    step = 1'b1;
    cyc(3);
    step = 1'b0;
    cyc(12);
    chk("t3_glitch_ticks", ticks - t0, 32'd0);
    s0 = seq_q.size();
    press("t3_press", 10);
    chk("t3_seq_step", 32'(seq_q[s0]), 32'd1);
    chk("t3_seq_halt", 32'(seq_q[s0 + 1]), 32'd0);

    // 4: breakpoint at 0xC after three instructions, step past it
    pc_clr = 1'b1;
    cyc(1);
    pc_clr = 1'b0;
    bp_enable = 1'b1;
    bp_addr   = 32'h0000_000C;
    t0 = ticks;
    run = 1'b1;
    cyc(30);
    chk("t4_bp_ticks", ticks - t0, 32'd3);
    chk("t4_bp_state", 32'(state), 32'd3);
    chk("t4_bp_hit", 32'(break_hit), 32'd1);
    t1 = ticks;
    cyc(6);
    chk("t4_break_no_tick", ticks - t1, 32'd0);
    s0 = seq_q.size();
    step = 1'b1;
    cyc(6);
    step = 1'b0;
    cyc(20);
    chk("t4_seq_step", 32'(seq_q[s0]), 32'd1);
    chk("t4_seq_halt", 32'(seq_q[s0 + 1]), 32'd0);
    chk("t4_seq_run", 32'(seq_q[s0 + 2]), 32'd2);
    chk("t4_resumed", 32'(ticks - t1 >= 5), 32'd1);
    chk("t4_state_run", 32'(state), 32'd2);
    run = 1'b0;
    cyc(4);
    bp_enable = 1'b0;
    exp_cnt = exp_cnt + 32'(ticks - t0);
    chk("t4_count", cycle_count, exp_cnt);

    // Randomised bursts and presses against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0)
        burst("rnd_burst", int'($urandom_range(4, 40)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 6)), 1'b0, got);
      else
        press("rnd_press", int'($urandom_range(1, 8)));
    end

    // 5: clear wins over a coincident tick; counter wrap
    run = 1'b1;
    for (int i = 0; i < 10 && !cpu_tick; i++) cyc(1);
    chk("t5_tick_seen", 32'(cpu_tick), 32'd1);
    clr_count = 1'b1;
    cyc(1);
    clr_count = 1'b0;
    run = 1'b0;
    chk("t5_clr_count", cycle_count, 32'd0);
    cyc(4);
    chk("t5_clr_hold", cycle_count, 32'd0);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    cyc(1);
    release dut.cycle_count_q;
    cyc(1);
    chk("t5_preload", cycle_count, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    press("t5_wrap", 8);
    chk("t5_wrap_zero", cycle_count, 32'd0);

    // 6: asynchronous reset coincident with a tick
    run = 1'b1;
    for (int i = 0; i < 10 && !cpu_tick; i++) cyc(1);
    chk("t6_tick_seen", 32'(cpu_tick), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tick", 32'(cpu_tick), 32'd0);
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_count", cycle_count, 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("t6_release_tick", 32'(cpu_tick), 32'd0);
    chk("t6_release_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
